// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// Optional rotating priority is enabled by defining PRIO_ENC_RR_EN.
package prio_enc_pkg;

    // Default number of request lines
    localparam int unsigned N_DEF = 8;
    // Widest request vector the multi-hot helper accepts
    localparam int unsigned N_MAX = 1024;

    // Ceiling log2 for n >= 2; used to derive the index width
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something
    function automatic logic popcount_gt1(input logic [N_MAX-1:0] vec);
        return |(vec & (vec - N_MAX'(1)));
    endfunction

endpackage

// File: rtl/prio_enc_find.sv
// Combinational find-highest-set over N bits.
// Ports: i_vec (N request bits), o_idx (index of highest set bit, 0 when none), o_found (any bit set).
module prio_enc_find #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    // Ascending scan: the last set bit seen is the highest one
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_pipe.sv
// Registered N:log2(N) priority encoder with valid/ready on both sides.
// Define PRIO_ENC_RR_EN for rotating priority (rr_ptr), otherwise highest index wins.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_req [N]            request vector
//   out_valid/out_ready   downstream handshake
//   out_idx [W]           winning index
//   out_none, out_multi   captured vector was zero / had more than one bit set
module prio_enc_pipe
    import prio_enc_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(N)-1:0]   out_idx,
    output logic                  out_none,
    output logic                  out_multi
);

    localparam int unsigned W = clog2(N);

    logic         r_out_valid;
    logic [W-1:0] r_out_idx;
    logic         r_out_none;
    logic         r_out_multi;

    logic         w_in_ready;
    logic         w_accept;
    logic [N-1:0] w_find_vec;
    logic [W-1:0] w_find_idx;
    logic         w_found;
    logic [W-1:0] w_idx;

    // Single stage: free when empty or being drained this cycle
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_accept   = in_valid && w_in_ready;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] r_rr_ptr;

    // Rotate so rr_ptr lands on bit N-1; a highest-set search then walks rr_ptr downward with wrap
    always_comb begin
        w_find_vec = '0;
        for (int unsigned j = 0; j < N; j++) begin
            w_find_vec[j] = in_req[W'((j + 32'(r_rr_ptr) + 32'd1) % N)];
        end
    end

    // Undo the rotation on the found position
    assign w_idx = W'((32'(w_find_idx) + 32'(r_rr_ptr) + 32'd1) % N);

    // Next search starts just below the winner; empty vectors leave the pointer alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= W'(N - 1);
        end else if (w_accept && w_found) begin
            r_rr_ptr <= (w_idx == '0) ? W'(N - 1) : w_idx - W'(1);
        end
    end
`else
    assign w_find_vec = in_req;
    assign w_idx      = w_find_idx;
`endif

    prio_enc_find #(
        .N (N),
        .W (W)
    ) u_find (
        .i_vec   (w_find_vec),
        .o_idx   (w_find_idx),
        .o_found (w_found)
    );

    // Output stage: load on accept, drop valid on drain, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_none  <= 1'b0;
            r_out_multi <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= w_found ? w_idx : '0;
            r_out_none  <= !w_found;
            r_out_multi <= popcount_gt1(N_MAX'(in_req));
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_none  = r_out_none;
    assign out_multi = r_out_multi;

endmodule

// File: tb/tb_prio_enc_pipe.sv
// Scoreboard bench for prio_enc_pipe; honours PRIO_ENC_RR_EN in its reference model.
module tb_prio_enc_pipe;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic         out_none;
    logic         out_multi;

    always #5 clk = ~clk;

    prio_enc_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_multi (out_multi)
    );

    typedef struct packed {
        logic [W-1:0] idx;
        logic         none;
        logic         multi;
    } res_t;

    res_t q[$];
    res_t hold;
    bit   seen_rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    int   model_rr = 0;
    int   n0;
`ifdef PRIO_ENC_RR_EN
    int   exp_ff[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
    int   exp_ff[9] = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference encoder: explicit search order, independent of the RTL rotation scheme
    task automatic model(input logic [N-1:0] v, output res_t r);
        int k;
        r.none  = (v == '0);
        r.multi = ($countones(v) > 1);
        r.idx   = '0;
`ifdef PRIO_ENC_RR_EN
        for (int s = 0; s < int'(N); s++) begin
            k = (model_rr - s + int'(N)) % int'(N);
            if (v[W'(k)]) begin
                r.idx = W'(k);
                break;
            end
        end
        if (!r.none) model_rr = (r.idx == '0) ? int'(N) - 1 : int'(r.idx) - 1;
`else
        for (k = int'(N) - 1; k >= 0; k--) begin
            if (v[W'(k)]) begin
                r.idx = W'(k);
                break;
            end
        end
`endif
    endtask

    // Check outputs against the scoreboard, record the coming edge's events, advance one cycle
    task automatic step();
        res_t r;
        #1;
        if (seen_rst) begin
            chk("valid_vs_sb", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("sb_idx",   32'(out_idx),   32'(q[0].idx));
                chk("sb_none",  32'(out_none),  32'(q[0].none));
                chk("sb_multi", 32'(out_multi), 32'(q[0].multi));
            end else if (!out_valid) begin
                chk("idle_idx",   32'(out_idx),   32'(hold.idx));
                chk("idle_none",  32'(out_none),  32'(hold.none));
                chk("idle_multi", 32'(out_multi), 32'(hold.multi));
            end
        end
        if (!rst_n) begin
            q.delete();
            hold     = '0;
            model_rr = int'(N) - 1;
            seen_rst = 1'b1;
        end else begin
            if (out_valid && out_ready && q.size() != 0) begin
                hold = q.pop_front();
                n_pops++;
            end
            if (in_valid && in_ready) begin
                model(in_req, r);
                q.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [N-1:0] v);
        in_valid  = 1'b1;
        in_req    = v;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        in_req    = 'x;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_req    = '0;
        @(negedge clk);
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx",   32'(out_idx),   32'd0);
        chk("rst_none",  32'(out_none),  32'd0);
        chk("rst_multi", 32'(out_multi), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // Multi-hot vector, highest bit wins
        send(8'h48);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_idx",   32'(out_idx),   32'd6);
        chk("t2_multi", 32'(out_multi), 32'd1);
        chk("t2_none",  32'(out_none),  32'd0);

        // Zero vector, then lowest bit alone
        send(8'h00);
        chk("t3_none",  32'(out_none),  32'd1);
        chk("t3_idx",   32'(out_idx),   32'd0);
        chk("t3_multi", 32'(out_multi), 32'd0);
        send(8'h01);
        chk("t3b_idx",  32'(out_idx),   32'd0);
        chk("t3b_none", 32'(out_none),  32'd0);

        // Backpressure: result holds, new vector waits
        send(8'h0F);
        out_ready = 1'b0;
        step();
        chk("t4_idx_a",  32'(out_idx),  32'd3);
        chk("t4_ready",  32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_req   = 8'h80;
        step();
        step();
        chk("t4_hold_idx", 32'(out_idx),   32'd3);
        chk("t4_hold_vld", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("t4_new_idx", 32'(out_idx),   32'd7);
        chk("t4_new_vld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        step();
        chk("t4_drain_vld",  32'(out_valid), 32'd0);
        chk("t4_drain_keep", 32'(out_idx),   32'd7);

        // Back-to-back stream, then reset mid-stream
        n0 = n_pops;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_req    = N'($urandom);
            step();
            chk("t5_b2b_valid", 32'(out_valid), 32'd1);
        end
        chk("t5_pops", 32'(n_pops - n0), 32'd15);
        in_req = N'($urandom);
        rst_n  = 1'b0;
        step();
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_idx",   32'(out_idx),   32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step();

        // All-ones vector repeated: rotating sequence or constant top index
        for (int i = 0; i < 9; i++) begin
            send(8'hFF);
            chk("t6_seq", 32'(out_idx), 32'(exp_ff[i]));
        end
        step();
        step();
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
